serial_adder_sequencer: RTL and testbench

Bit-serial add/subtract engine that time-shares one `FullAdder1Bit` instance across all `WIDTH` operand bits. It is the area-minimal arithmetic path of the 128-bit ALU and sits beside the parallel adder, selected by the ALU top for low-area builds. The block:
- captures both operands on a start request;
- steps the single full adder LSB-first, one bit per clock, with a registered carry;
- returns the `WIDTH`-bit result, carry-out and (optionally) signed overflow with a done pulse.

---
 rtl/serial_adder_sequencer.sv | 99 +++++++++
 tb/tb_serial_adder_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sequencer.sv
// serial_adder_sequencer: bit-serial add/subtract, one shared full adder stepped LSB-first.
// Define SERIAL_ADDER_OVERFLOW_EN to build the signed-overflow flag (Overflow tied to 0 otherwise).
module FullAdder1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Result,
    output logic Cout
);
    assign Result = A ^ B ^ Cin;
    assign Cout   = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_sequencer #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0] cnt;
    logic sub_q, c, fa_s, fa_c, last, step;
    FullAdder1Bit u_fa (
        .A(a_sh[0]),
        .B(b_sh[0] ^ sub_q),
        .Cin(c),
        .Result(fa_s),
        .Cout(fa_c)
    );
    assign last = cnt == CW'(WIDTH - 1);
    assign step = state == RUN && !abort;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        if (abort) state_n = IDLE;
        else if (state == IDLE) state_n = start ? RUN : IDLE;
        else if (state == RUN) state_n = last ? DONE : RUN;
        else state_n = IDLE;
    end
    // busy/done come straight from flops so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            sub_q  <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            Result <= '0;
            Cout   <= 1'b0;
        end else begin
            busy <= state_n == RUN;
            done <= state_n == DONE;
            if (state == IDLE && state_n == RUN) begin
                a_sh  <= A;
                b_sh  <= B;
                sub_q <= sub;
                c     <= sub;
                cnt   <= '0;
            end else if (step) begin
                r_sh <= {fa_s, r_sh[WIDTH-1:1]};
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                c    <= fa_c;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    Result <= {fa_s, r_sh[WIDTH-1:1]};
                    Cout   <= fa_c;
                end
            end
        end
    end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic c_msb_in;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) c_msb_in <= 1'b0;
        else if (step && last) c_msb_in <= c;
    assign Overflow = c_msb_in ^ Cout;
`else
    assign Overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_sequencer.sv
// tb_serial_adder_sequencer: directed stimulus on a 128-bit and an 8-bit instance,
// expected results queued at issue time and checked by per-instance done monitors.
module tb_serial_adder_sequencer;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif
    typedef struct {
        logic [127:0] r;
        logic         co;
        logic         ov;
        int           t;
        string        n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic s1, sb1, ab1, bz1, dn1, co1, ov1;
    logic [127:0] a1, b1, r1;
    logic s2, sb2, ab2, bz2, dn2, co2, ov2;
    logic [7:0] a2, b2, r2;
    int checks = 0, fails = 0, k;
    exp_t q1[$], q2[$];

    serial_adder_sequencer #(.WIDTH(128)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(s1), .sub(sb1), .abort(ab1), .A(a1), .B(b1),
        .busy(bz1), .done(dn1), .Result(r1), .Cout(co1), .Overflow(ov1)
    );
    serial_adder_sequencer #(.WIDTH(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(s2), .sub(sb2), .abort(ab2), .A(a2), .B(b2),
        .busy(bz2), .done(dn2), .Result(r2), .Cout(co2), .Overflow(ov2)
    );

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic push(input bit wide, input logic [127:0] r, input logic co, input logic ov, input string n);
        exp_t e;
        e.r  = r;
        e.co = co;
        e.ov = ov;
        e.n  = n;
        e.t  = cyc + 1 + (wide ? 128 : 8);
        if (wide) q1.push_back(e);
        else q2.push_back(e);
    endtask

    always @(negedge clk) begin : mon_w
        exp_t e;
        if (bz1 && dn1) chk("w_busy_and_done", 128'(1), 128'(0));
        if (dn1) begin
            if (q1.size() == 0) chk("w_spurious_done", 128'(1), 128'(0));
            else begin
                e = q1.pop_front();
                chk({e.n, "_res"}, r1, e.r);
                chk({e.n, "_cout"}, 128'(co1), 128'(e.co));
                chk({e.n, "_ovf"}, 128'(ov1), 128'(e.ov));
                chk({e.n, "_lat"}, 128'(cyc), 128'(e.t));
            end
        end
    end

    always @(negedge clk) begin : mon_n
        exp_t e;
        if (bz2 && dn2) chk("n_busy_and_done", 128'(1), 128'(0));
        if (dn2) begin
            if (q2.size() == 0) chk("n_spurious_done", 128'(1), 128'(0));
            else begin
                e = q2.pop_front();
                chk({e.n, "_res"}, 128'(r2), e.r);
                chk({e.n, "_cout"}, 128'(co2), 128'(e.co));
                chk({e.n, "_ovf"}, 128'(ov2), 128'(e.ov));
                chk({e.n, "_lat"}, 128'(cyc), 128'(e.t));
            end
        end
    end

    task automatic op_w(input logic [127:0] a, input logic [127:0] b, input logic [127:0] er, input logic eco, input string n);
        @(negedge clk);
        a1 = a; b1 = b; sb1 = 1'b0; s1 = 1'b1;
        push(1'b1, er, eco, 1'b0, n);
        @(negedge clk);
        s1 = 1'b0; a1 = ~a; b1 = ~b;
        repeat (130) @(negedge clk);
    endtask

    task automatic op_n(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] er, input logic eco, input logic eov, input string n);
        @(negedge clk);
        a2 = a; b2 = b; sb2 = s; s2 = 1'b1;
        push(1'b0, 128'(er), eco, eov, n);
        @(negedge clk);
        s2 = 1'b0; a2 = ~a; b2 = ~b; sb2 = ~s;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [7:0] hs_r [3];
        hs_r = '{8'h03, 8'h2B, 8'h53};
        rst_n = 1'b0;
        {s1, sb1, ab1, s2, sb2, ab2} = '0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'({bz1, bz2}), 128'(0));
        chk("rst_done", 128'({dn1, dn2}), 128'(0));
        chk("rst_res", r1 | 128'(r2), 128'(0));
        chk("rst_flags", 128'({co1, ov1, co2, ov2}), 128'(0));
        rst_n = 1'b1;

        op_w({128{1'b1}}, 128'd1, 128'd0, 1'b1, "w_add_max");
        op_w({128{1'b1}}, 128'd2, 128'd1, 1'b1, "w_add_wrap");

        @(negedge clk);
        a1 = 128'h1234; b1 = 128'h5678; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        repeat (40) @(negedge clk);
        chk("w_busy_mid", 128'(bz1), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("w_rst_busy", 128'(bz1), 128'(0));
        chk("w_rst_done", 128'(dn1), 128'(0));
        chk("w_rst_res", r1, 128'(0));
        chk("w_rst_cout", 128'(co1), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (140) @(negedge clk);
        chk("w_idle_after_rst", 128'(bz1), 128'(0));

        op_n(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "n_sub_borrow");
        op_n(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OV, "n_add_ovf");
        op_n(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OV, "n_sub_ovf");
        op_n(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, "n_add_neg");

        @(negedge clk);
        for (int j = 0; j < 30; j++) begin
            s2 = 1'b1; sb2 = 1'b0;
            a2 = 8'(j * 3 + 1);
            b2 = 8'(j + 2);
            if (j % 10 == 0) push(1'b0, 128'(hs_r[j / 10]), 1'b0, 1'b0, $sformatf("n_hold%0d", j / 10));
            @(negedge clk);
        end
        s2 = 1'b0;
        repeat (12) @(negedge clk);

        a2 = 8'h11; b2 = 8'h22; sb2 = 1'b0; s2 = 1'b1;
        push(1'b0, 128'(8'h33), 1'b0, 1'b0, "n_pulse");
        @(negedge clk);
        s2 = 1'b0;
        repeat (2) @(negedge clk);
        s2 = 1'b1; a2 = 8'h55;
        @(negedge clk);
        s2 = 1'b0;
        repeat (5) @(negedge clk);
        s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        repeat (12) @(negedge clk);

        op_n(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "n_abort_prior");
        @(negedge clk);
        a2 = 8'h01; b2 = 8'h01; sb2 = 1'b0; s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        repeat (2) @(negedge clk);
        ab2 = 1'b1; s2 = 1'b1; a2 = 8'h40; b2 = 8'h40;
        @(negedge clk);
        ab2 = 1'b0; s2 = 1'b0;
        chk("n_abort_busy", 128'(bz2), 128'(0));
        repeat (12) @(negedge clk);
        chk("n_abort_res", 128'(r2), 128'(8'h30));
        chk("n_abort_idle", 128'(bz2), 128'(0));

        chk("w_queue_drained", 128'(q1.size()), 128'(0));
        chk("n_queue_drained", 128'(q2.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
